signed_vector_addsub_pipe: RTL
==============================

// Module: signed_vector_addsub_pipe
// PURPOSE
//  Parametrised, pipelined successor to the combinational signed vector adder in the ray-tracing datapath.
//  Adds or subtracts two packed signed vectors of N_COMP two's-complement components (default 3 x 19 b = 57 b).
//  Has a valid/ready handshake, per-component overflow flags and a per-transaction add/sub mode.
//  Sits between the ray/vector generation stages and the dot/cross-product units.
// PARAMETERS
//  N_COMP   3   number of components per vector (>=1)
//  COMP_W   19  width of each signed component in bits (>=2); VEC_W = N_COMP*COMP_W (localparam)
// PORTS
//  clk            in   1        single clock; all logic on rising edge
//  rst_n          in   1        synchronous, active-low reset
//  in_valid       in   1        input transaction valid
//  in_ready       out  1        block can accept input this cycle
//  in_sub         in   1        0: out = v1 + v2; 1: out = v1 - v2 (sampled with the transaction)
//  in_vector_1    in   VEC_W    component k at [k*COMP_W +: COMP_W], component 0 at LSBs
//  in_vector_2    in   VEC_W    same packing as in_vector_1
//  out_valid      out  1        result valid
//  out_ready      in   1        downstream accepts result
//  out_vector     out  VEC_W    result, same packing
//  out_overflow   out  N_COMP   bit k set when component k's exact result is outside COMP_W signed range
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): s1_valid=0, out_valid=0, out_vector=0, out_overflow=0. Pipeline contents are discarded.
//    Reset mid-operation drops in-flight data with no partial output.
//  - Transfer rules: input transfer on in_valid&in_ready; output transfer on out_valid&out_ready.
//  - Stage 1: registers the operands and in_sub. Stage 2: computes the result and registers out_vector/out_overflow/out_valid.
//  - Latency: 2 cycles from input transfer to out_valid, with no stalls. Throughput: 1 transaction/cycle.
//  - Stall logic: s2_adv = !out_valid | out_ready; s1_adv = s1_valid & s2_adv; in_ready = !s1_valid | s2_adv.
//  - in_ready depends only on registered state and out_ready (no in_valid->in_ready path).
//  - Held data: when !s2_adv, out_vector, out_overflow and out_valid hold stable. Data is never lost or duplicated.
//  - Simultaneous events: input and output transfers in the same cycle are legal.
//    When s1 is full and out_ready=1, s1 moves to s2 while new data loads into s1.
//  - Arithmetic per component k, in COMP_W+1 bits, sign-extended:
//    r = a + b (add) or a - b (sub). ovf_k = (r[COMP_W] != r[COMP_W-1]).
//  - Default result is r[COMP_W-1:0] (two's-complement wrap).
//  - Sub with b = -2^(COMP_W-1) is handled exactly; for example, 0 - min gives ovf=1.
//  - Components are independent: no carry crosses component boundaries.
//  - out_valid=0: out_vector and out_overflow keep their last values (0 after reset).
// CONFIGURATION
//  SIGNED_VEC_SAT_EN defined: an overflowing component clamps to +2^(COMP_W-1)-1 when r>0,
//    or to -2^(COMP_W-1) when r<0. out_overflow still reports the overflow.
//  SIGNED_VEC_SAT_EN undefined: the result wraps (low COMP_W bits of r). Latency and handshake are identical in both builds.
// TESTING (N_COMP=3, COMP_W=19; max=0x3FFFF, min=0x40000)
//  1. Reset then idle -> out_valid=0, in_ready=1, out_vector=0, out_overflow=3'b000.
//  2. add, v1={5,-3,100}, v2={-7,3,28}, out_ready=1 -> 2 cycles later out={-2,0,128}, ovf=000, one out_valid pulse.
//  3. add comp0: max+1; sub comp1: 0-min; comp2: min-1 -> ovf=3'b111.
//     Wrap build: {min, min, max}. SAT build: {max, max, min}.
//  4. 8 back-to-back transactions with out_ready held 0 for 5 cycles mid-stream
//     -> in_ready=0 once both stages are full; all 8 results emerge in order, none dropped or duplicated, out data stable while stalled.
//  5. Random in_valid/out_ready (50%), 10k transactions -> results match the reference model, order preserved.
//  6. rst_n=0 for 1 cycle with both stages full -> next cycle out_valid=0, in_ready=1; the next input produces a correct result after 2 cycles.

Source files
------------

// File: rtl/signed_vector_addsub_pipe.sv
// signed_vector_addsub_pipe
//   Two-stage pipelined add/subtract of two packed signed vectors. Each vector
//   holds N_COMP two's-complement components of COMP_W bits; component k sits at
//   [k*COMP_W +: COMP_W], with component 0 in the LSBs. Every component also
//   reports whether its exact result falls outside the COMP_W signed range.
//
//   Optional build macro: SIGNED_VEC_SAT_EN
//     defined   -> an overflowing component clamps to the signed max or min
//     undefined -> an overflowing component wraps (low COMP_W bits kept)
//   Latency and handshake are the same in both builds.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   in_valid      upstream offers a transaction
//   in_ready      block accepts a transaction this cycle
//   in_sub        0: v1 + v2, 1: v1 - v2 (captured with the transaction)
//   in_vector_1   packed operand 1
//   in_vector_2   packed operand 2
//   out_valid     result is valid
//   out_ready     downstream accepts the result
//   out_vector    packed result
//   out_overflow  bit k set when component k overflowed
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its data stable until the
// transfer; ready never depends on valid in the same cycle.
module signed_vector_addsub_pipe #(
   parameter int N_COMP = 3,
   parameter int COMP_W = 19
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_sub,
   input  logic [N_COMP*COMP_W-1:0]   in_vector_1,
   input  logic [N_COMP*COMP_W-1:0]   in_vector_2,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N_COMP*COMP_W-1:0]   out_vector,
   output logic [N_COMP-1:0]          out_overflow
);

   localparam int VEC_W = N_COMP * COMP_W;

   // Stage 1 holding registers
   logic              s1_valid;
   logic              s1_sub;
   logic [VEC_W-1:0]  s1_a;
   logic [VEC_W-1:0]  s1_b;

   logic              s2_adv;
   logic              s1_adv;
   logic              in_fire;

   logic [VEC_W-1:0]  res_vec;
   logic [N_COMP-1:0] res_ovf;

   // Output stage moves when empty or drained this cycle; stage 1 moves
   // when it holds data and the output stage can take it.
   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = s1_valid && s2_adv;
   assign in_ready = !s1_valid || s2_adv;
   assign in_fire  = in_valid && in_ready;

   // Per-component arithmetic, one extra bit so the exact result is kept.
   // Independent slices: no carry crosses a component boundary.
   for (genvar k = 0; k < N_COMP; k++) begin : g_comp
      logic signed [COMP_W:0] a_ext;
      logic signed [COMP_W:0] b_ext;
      logic signed [COMP_W:0] r;

      assign a_ext = {s1_a[k*COMP_W+COMP_W-1], s1_a[k*COMP_W +: COMP_W]};
      assign b_ext = {s1_b[k*COMP_W+COMP_W-1], s1_b[k*COMP_W +: COMP_W]};
      // With the extra bit, 0 - min is representable, so subtract is exact.
      assign r     = s1_sub ? (a_ext - b_ext) : (a_ext + b_ext);
      // Top two bits disagree exactly when r is outside the COMP_W range.
      assign res_ovf[k] = r[COMP_W] ^ r[COMP_W-1];

`ifdef SIGNED_VEC_SAT_EN
      // r[COMP_W] is the true sign of the exact result.
      assign res_vec[k*COMP_W +: COMP_W] =
         !res_ovf[k] ? r[COMP_W-1:0] :
         (r[COMP_W] ? {1'b1, {(COMP_W-1){1'b0}}}
                    : {1'b0, {(COMP_W-1){1'b1}}});
`else
      assign res_vec[k*COMP_W +: COMP_W] = r[COMP_W-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid     <= 1'b0;
         s1_sub       <= 1'b0;
         s1_a         <= '0;
         s1_b         <= '0;
         out_valid    <= 1'b0;
         out_vector   <= '0;
         out_overflow <= '0;
      end else begin
         // Stage 1: a new load wins over emptying, which covers the
         // simultaneous move-and-refill case.
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_sub   <= in_sub;
            s1_a     <= in_vector_1;
            s1_b     <= in_vector_2;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end

         // Stage 2: result data only changes when a new result arrives, so
         // it holds its last value while out_valid is low.
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_vector   <= res_vec;
               out_overflow <= res_ovf;
            end
         end
      end
   end

endmodule
